// File: rtl/uart_rx_ovs_if.sv
// Output side of the oversampling UART receiver: received word, error flags
// and the single-entry valid/ready handshake toward the consumer.
interface uart_rx_ovs_if #(
  parameter int N_DATA = 8
);
  logic [N_DATA-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_parity_err;
  logic              o_frame_err;
  logic              o_break;
  logic              o_overrun;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 3-sample majority vote per bit, false-start
// rejection, runtime frame format, and a single-entry output register.
module uart_rx_ovs #(
  parameter int N_DATA     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int NB_TICK    = 4,
  parameter int NB_BITCNT  = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_tick,
  input  logic         i_rx,
  input  logic [3:0]   i_cfg_nbits,
  input  logic [1:0]   i_cfg_parity,
  input  logic         i_cfg_stop2,
  uart_rx_ovs_if.master rx_out
);

  localparam int H = OVERSAMPLE / 2;
  localparam logic [NB_TICK-1:0] T_S0  = NB_TICK'(H - 1);
  localparam logic [NB_TICK-1:0] T_S1  = NB_TICK'(H);
  localparam logic [NB_TICK-1:0] T_DEC = NB_TICK'(H + 1);
  localparam logic [NB_TICK-1:0] T_END = NB_TICK'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                state, state_nxt;
  logic                  rx_meta, rx_s;
  logic [NB_TICK-1:0]    tick_cnt;
  logic [NB_BITCNT-1:0]  bit_cnt;
  logic                  samp_a, samp_b;
  logic [N_DATA-1:0]     shreg;
  logic [NB_BITCNT-1:0]  nbits_q;
  logic                  par_en_q, par_odd_q, stop2_q;
  logic                  perr_q, ferr_q, pbit_q;

  logic                  decide, end_bit, bit_val, last_stop, frame_err_now;
  logic                  complete;
  logic [NB_BITCNT-1:0]  nbits_cfg;

  // NOTE: the synchronizer resets to 1 so a reset never looks like a start bit.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  assign decide        = i_tick && (tick_cnt == T_DEC);
  assign end_bit       = i_tick && (tick_cnt == T_END);
  assign bit_val       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign last_stop     = !stop2_q || (bit_cnt == NB_BITCNT'(1));
  assign frame_err_now = ferr_q | ~bit_val;
  assign nbits_cfg     = (i_cfg_nbits < 4'd5 || i_cfg_nbits > 4'(N_DATA))
                         ? NB_BITCNT'(N_DATA) : NB_BITCNT'(i_cfg_nbits);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    unique case (state)
      S_IDLE:   if (i_tick && !rx_s) state_nxt = S_START;
      S_START: begin
        if (decide && bit_val) state_nxt = S_IDLE;
        else if (end_bit)      state_nxt = S_DATA;
      end
      S_DATA:
        if (end_bit && (bit_cnt == nbits_q - NB_BITCNT'(1)))
          state_nxt = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (end_bit) state_nxt = S_STOP;
      S_STOP: begin
        if (decide && last_stop) begin
          complete  = 1'b1;
          state_nxt = frame_err_now ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK:  if (i_tick && rx_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge values of its neighbours.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      shreg     <= '0;
      nbits_q   <= NB_BITCNT'(N_DATA);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      pbit_q    <= 1'b0;
    end else if (i_tick) begin
      if (state == S_IDLE || state == S_BREAK ||
          state_nxt == S_IDLE || state_nxt == S_BREAK || tick_cnt == T_END)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;

      if (state_nxt != state)
        bit_cnt <= '0;
      else if (end_bit && (state == S_DATA || state == S_STOP))
        bit_cnt <= bit_cnt + 1'b1;

      if (tick_cnt == T_S0) samp_a <= rx_s;
      if (tick_cnt == T_S1) samp_b <= rx_s;

      unique case (state)
        S_IDLE: begin
          if (state_nxt == S_START) begin
            shreg  <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            pbit_q <= 1'b0;
          end
        end
        S_START: begin
          // Frame format is frozen once a genuine start bit has been confirmed.
          if (decide && !bit_val) begin
            nbits_q   <= nbits_cfg;
            par_en_q  <= (i_cfg_parity == 2'b01) || (i_cfg_parity == 2'b10);
            par_odd_q <= (i_cfg_parity == 2'b10);
            stop2_q   <= i_cfg_stop2;
          end
        end
        S_DATA: begin
          if (decide)
            for (int i = 0; i < N_DATA; i++)
              if (bit_cnt == NB_BITCNT'(i)) shreg[i] <= bit_val;
        end
        S_PARITY: begin
          if (decide) begin
            pbit_q <= bit_val;
            perr_q <= (^shreg) ^ bit_val ^ par_odd_q;
          end
        end
        S_STOP: if (decide && !bit_val) ferr_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Output register: a completing frame may replace a word being accepted in
  // the same cycle; otherwise it is dropped and flagged as an overrun.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_out.o_data       <= '0;
      rx_out.o_valid      <= 1'b0;
      rx_out.o_parity_err <= 1'b0;
      rx_out.o_frame_err  <= 1'b0;
      rx_out.o_break      <= 1'b0;
      rx_out.o_overrun    <= 1'b0;
    end else begin
      rx_out.o_overrun <= 1'b0;
      if (complete) begin
        if (!rx_out.o_valid || rx_out.i_ready) begin
          rx_out.o_data       <= shreg;
          rx_out.o_valid      <= 1'b1;
          rx_out.o_parity_err <= perr_q;
          rx_out.o_frame_err  <= frame_err_now;
          rx_out.o_break      <= frame_err_now && (shreg == '0) && !pbit_q;
        end else begin
          rx_out.o_overrun <= 1'b1;
        end
      end else if (rx_out.o_valid && rx_out.i_ready) begin
        rx_out.o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: directed frame table, hand-written
// corner sequences and randomized frames against a frame-level decode model.
module tb_uart_rx_ovs;

  localparam int OVS = 16;
  localparam int H   = OVS / 2;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } word_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] nbits;
    logic [1:0] par;
    bit         stop2;
    bit         pbit;
    bit         stop_a;
    bit         stop_b;
    word_t      exp;
  } vec_t;

  logic       i_clock, i_reset, i_tick, i_rx, i_cfg_stop2;
  logic [3:0] i_cfg_nbits;
  logic [1:0] i_cfg_parity;
  bit         tick_en, rand_ready;
  int         tdiv;
  int         n_vec, n_err;
  int         valid_cyc, ovr_cnt;
  word_t      rxq[$];

  uart_rx_ovs_if #(.N_DATA(8)) rx_if ();

  uart_rx_ovs #(.N_DATA(8), .OVERSAMPLE(OVS), .NB_TICK(4), .NB_BITCNT(4)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_tick       (i_tick),
    .i_rx         (i_rx),
    .i_cfg_nbits  (i_cfg_nbits),
    .i_cfg_parity (i_cfg_parity),
    .i_cfg_stop2  (i_cfg_stop2),
    .rx_out       (rx_if)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // One tick every 4 clocks, changed on the falling edge.
  always @(negedge i_clock) begin
    if (!tick_en) i_tick = 1'b0;
    else begin
      tdiv   = (tdiv == 3) ? 0 : tdiv + 1;
      i_tick = (tdiv == 0);
    end
  end

  always @(negedge i_clock)
    if (rand_ready) rx_if.i_ready = ($urandom_range(0, 3) != 0);

  // Consumer: records every accepted word and counts valid/overrun cycles.
  always @(negedge i_clock) begin
    #1;
    if (i_reset) begin
      if (rx_if.o_valid && rx_if.i_ready)
        rxq.push_back('{rx_if.o_data, rx_if.o_parity_err, rx_if.o_frame_err, rx_if.o_break});
      if (rx_if.o_valid)   valid_cyc++;
      if (rx_if.o_overrun) ovr_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick1();
    int guard = 0;
    do begin
      @(posedge i_clock);
      guard++;
    end while (!i_tick && guard < 100);
    if (!i_tick) begin
      $display("FAIL tick_wait: no tick within 100 clocks");
      $fatal(1, "tick generator stalled");
    end
    @(negedge i_clock);
  endtask

  task automatic drive_bit(input logic v, input int glitch_off);
    for (int k = 0; k < OVS; k++) begin
      i_rx = (k == glitch_off) ? ~v : v;
      tick1();
    end
  endtask

  function automatic int clamp_n(input logic [3:0] nb);
    return (nb < 5 || nb > 8) ? 8 : int'(nb);
  endfunction

  // Frame-level decode of what the receiver must report for a given frame.
  function automatic word_t model(input logic [7:0] data, input logic [3:0] nb,
                                  input logic [1:0] par, input bit stop2,
                                  input bit pbit, input bit sa, input bit sb);
    word_t w;
    int    n    = clamp_n(nb);
    int    d    = int'(data) & ((1 << n) - 1);
    bit    pen  = (par == 2'b01) || (par == 2'b10);
    int    ones = $countones(d[7:0]) + int'(pbit);
    w.data = d[7:0];
    w.perr = pen && ((ones % 2) != ((par == 2'b10) ? 1 : 0));
    w.ferr = !sa || (stop2 && !sb);
    w.brk  = w.ferr && (d == 0) && (!pen || !pbit);
    return w;
  endfunction

  task automatic send_frame(input logic [7:0] data, input logic [3:0] nb,
                            input logic [1:0] par, input bit stop2, input bit pbit,
                            input bit sa, input bit sb, input int glitch_bit,
                            input int freeze_bit, input int idle_ticks);
    int n   = clamp_n(nb);
    bit pen = (par == 2'b01) || (par == 2'b10);
    i_cfg_nbits  = nb;
    i_cfg_parity = par;
    i_cfg_stop2  = stop2;
    drive_bit(1'b0, -1);
    // Config must already be captured; scramble it for the rest of the frame.
    i_cfg_nbits  = 4'($urandom);
    i_cfg_parity = 2'($urandom);
    i_cfg_stop2  = 1'($urandom);
    for (int j = 0; j < n; j++) begin
      drive_bit(data[j], (j == glitch_bit) ? H + 1 : -1);
      if (j == freeze_bit) begin
        tick_en = 1'b0;
        repeat (300) @(negedge i_clock);
        tick_en = 1'b1;
      end
    end
    if (pen) drive_bit(pbit, -1);
    drive_bit(sa, -1);
    if (stop2) drive_bit(sb, -1);
    i_rx = 1'b1;
    repeat (idle_ticks) tick1();
  endtask

  task automatic expect_word(input string tag, input word_t exp);
    int    guard = 0;
    word_t got;
    while (rxq.size() == 0 && guard < 3000) begin
      @(negedge i_clock);
      guard++;
    end
    if (rxq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: no word received, expected data %0h", tag, exp.data);
    end else begin
      got = rxq.pop_front();
      check({tag, " data"}, 32'(got.data), 32'(exp.data));
      check({tag, " perr"}, 32'(got.perr), 32'(exp.perr));
      check({tag, " ferr"}, 32'(got.ferr), 32'(exp.ferr));
      check({tag, " brk"},  32'(got.brk),  32'(exp.brk));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " o_data"},  32'(rx_if.o_data), 0);
    check({tag, " o_valid"}, 32'(rx_if.o_valid), 0);
    check({tag, " o_flags"}, 32'({rx_if.o_parity_err, rx_if.o_frame_err,
                                  rx_if.o_break, rx_if.o_overrun}), 0);
  endtask

  vec_t  vt[10];
  word_t w;
  int    vc0, ovr0;

  initial begin
    vt[0] = '{8'hA5, 4'd8,  2'b00, 0, 0, 1, 1, '{8'hA5, 0, 0, 0}};
    vt[1] = '{8'h35, 4'd7,  2'b01, 1, 1, 1, 1, '{8'h35, 1, 0, 0}};
    vt[2] = '{8'h35, 4'd7,  2'b01, 1, 0, 1, 1, '{8'h35, 0, 0, 0}};
    vt[3] = '{8'hFF, 4'd5,  2'b10, 0, 0, 1, 1, '{8'h1F, 0, 0, 0}};
    vt[4] = '{8'h80, 4'd3,  2'b10, 0, 1, 1, 1, '{8'h80, 1, 0, 0}};
    vt[5] = '{8'h00, 4'd8,  2'b01, 0, 1, 0, 1, '{8'h00, 1, 1, 0}};
    vt[6] = '{8'hC3, 4'd8,  2'b00, 1, 0, 0, 1, '{8'hC3, 0, 1, 0}};
    vt[7] = '{8'h00, 4'd8,  2'b00, 1, 0, 1, 0, '{8'h00, 0, 1, 1}};
    vt[8] = '{8'h5A, 4'd15, 2'b11, 0, 1, 1, 1, '{8'h5A, 0, 0, 0}};
    vt[9] = '{8'hFF, 4'd6,  2'b00, 0, 0, 1, 1, '{8'h3F, 0, 0, 0}};

    n_vec = 0; n_err = 0; valid_cyc = 0; ovr_cnt = 0; tdiv = 0;
    tick_en = 1'b1; rand_ready = 1'b0;
    i_reset = 1'b0; i_rx = 1'b1; rx_if.i_ready = 1'b1;
    i_cfg_nbits = 4'd8; i_cfg_parity = 2'b00; i_cfg_stop2 = 1'b0;

    repeat (5) @(negedge i_clock);
    #2 check_outputs_zero("reset");
    i_reset = 1'b1;
    repeat (16) tick1();

    // 8N1 word: one-cycle valid pulse with a ready consumer.
    vc0 = valid_cyc;
    send_frame(8'hA5, 4'd8, 2'b00, 0, 0, 1, 1, -1, -1, 16);
    expect_word("8n1_a5", '{8'hA5, 0, 0, 0});
    check("8n1_valid_cycles", 32'(valid_cyc - vc0), 1);

    foreach (vt[i]) begin
      send_frame(vt[i].data, vt[i].nbits, vt[i].par, vt[i].stop2, vt[i].pbit,
                 vt[i].stop_a, vt[i].stop_b, -1, -1, 16);
      expect_word($sformatf("table%0d", i), vt[i].exp);
    end

    // Short low pulse is a false start; then a glitched mid-sample is outvoted.
    i_rx = 1'b0;
    repeat (4) tick1();
    i_rx = 1'b1;
    repeat (40) tick1();
    check("false_start_words", 32'(rxq.size()), 0);
    send_frame(8'h3C, 4'd8, 2'b00, 0, 0, 1, 1, 2, -1, 16);
    expect_word("glitch_3c", '{8'h3C, 0, 0, 0});

    // Break: framing error on all-zero data, then a long low line.
    send_frame(8'h00, 4'd8, 2'b00, 0, 0, 0, 1, -1, -1, 0);
    i_rx = 1'b0;
    repeat (40) tick1();
    i_rx = 1'b1;
    repeat (16) tick1();
    expect_word("break_00", '{8'h00, 0, 1, 1});
    check("break_no_spurious", 32'(rxq.size()), 0);
    send_frame(8'h55, 4'd8, 2'b00, 0, 0, 1, 1, -1, -1, 16);
    expect_word("after_break_55", '{8'h55, 0, 0, 0});

    // Stalled consumer: second word dropped with a single overrun pulse.
    rx_if.i_ready = 1'b0;
    ovr0 = ovr_cnt;
    send_frame(8'h11, 4'd8, 2'b00, 0, 0, 1, 1, -1, -1, 8);
    send_frame(8'h22, 4'd8, 2'b00, 0, 0, 1, 1, -1, -1, 8);
    #2;
    check("stall_hold_data", 32'(rx_if.o_data), 32'h11);
    check("stall_hold_valid", 32'(rx_if.o_valid), 1);
    check("overrun_pulses", 32'(ovr_cnt - ovr0), 1);
    @(negedge i_clock);
    rx_if.i_ready = 1'b1;
    @(negedge i_clock);
    #2 check("valid_drop_after_ready", 32'(rx_if.o_valid), 0);
    expect_word("stall_11", '{8'h11, 0, 0, 0});
    check("overrun_dropped", 32'(rxq.size()), 0);

    // Tick enable held low mid-frame freezes reception without corruption.
    send_frame(8'h96, 4'd8, 2'b00, 0, 0, 1, 1, -1, 3, 16);
    expect_word("freeze_96", '{8'h96, 0, 0, 0});

    // Randomized frames against the decode model, with a jittery consumer.
    rand_ready = 1'b1;
    for (int r = 0; r < 20; r++) begin
      logic [7:0] d  = 8'($urandom);
      logic [3:0] nb = 4'($urandom);
      logic [1:0] pr = 2'($urandom);
      bit         s2 = 1'($urandom);
      bit         sa = ($urandom_range(0, 5) != 0);
      bit         sb = ($urandom_range(0, 5) != 0);
      int         n  = clamp_n(nb);
      int         dm = int'(d) & ((1 << n) - 1);
      bit         pb = 1'(($countones(dm[7:0]) % 2) ^ ((pr == 2'b10) ? 1 : 0));
      int         gb = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, n - 1)) : -1;
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      send_frame(d, nb, pr, s2, pb, sa, sb, gb, -1, $urandom_range(2, 20));
      w = model(d, nb, pr, s2, pb, sa, sb);
      expect_word($sformatf("rand%0d", r), w);
    end
    rand_ready = 1'b0;
    rx_if.i_ready = 1'b1;
    repeat (4) @(negedge i_clock);

    // Asynchronous reset mid-DATA with a word pending in the output register.
    rx_if.i_ready = 1'b0;
    send_frame(8'h42, 4'd8, 2'b00, 0, 0, 1, 1, -1, -1, 8);
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b0, -1);
    i_reset = 1'b0;
    #1 check_outputs_zero("reset_mid_data");
    i_rx = 1'b1;
    repeat (3) @(negedge i_clock);
    i_reset = 1'b1;
    rx_if.i_ready = 1'b1;
    repeat (20) tick1();
    check("reset_no_word", 32'(rxq.size()), 0);
    send_frame(8'h81, 4'd8, 2'b00, 0, 0, 1, 1, -1, -1, 16);
    expect_word("after_reset_81", '{8'h81, 0, 0, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
